// File: rtl/rinv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rinv_seq_ctrl_if
// Brief    : Upstream, datapath and downstream signal bundle for rinv_seq_ctrl.
//            err_singular exists only with RINV_SEQ_SINGULAR_CHECK_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface rinv_seq_ctrl_if #(
   parameter int SIZE = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] in_data;
   logic [SIZE-1:0] rin_00;
   logic [SIZE-1:0] rin_01;
   logic [SIZE-1:0] rin_02;
   logic [SIZE-1:0] rin_11;
   logic [SIZE-1:0] rin_12;
   logic [SIZE-1:0] rin_22;
   logic            rinv_start;
   logic            rinv_read;
   logic            rinv_dnload;
   logic            rinv_finish;
   logic [SIZE-1:0] rinv_elem;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] out_data;
   logic            out_last;
   logic            busy;
   logic            err_timeout;
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
   logic            err_singular;
`endif

   modport master (
      input  in_valid, in_data, rinv_dnload, rinv_finish, rinv_elem, out_ready,
      output in_ready, rin_00, rin_01, rin_02, rin_11, rin_12, rin_22,
             rinv_start, rinv_read, out_valid, out_data, out_last, busy, err_timeout
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
      , output err_singular
`endif
   );

   modport slave (
      output in_valid, in_data, rinv_dnload, rinv_finish, rinv_elem, out_ready,
      input  in_ready, rin_00, rin_01, rin_02, rin_11, rin_12, rin_22,
             rinv_start, rinv_read, out_valid, out_data, out_last, busy, err_timeout
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
      , input err_singular
`endif
   );
endinterface
`default_nettype wire

// File: rtl/rinv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rinv_seq_ctrl
// Brief    : Loads six R words, starts the 3x3 R-inverse datapath, captures and
//            replays its nine results. Option macro: RINV_SEQ_SINGULAR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rinv_seq_ctrl #(
   parameter int SIZE    = 16,
   parameter int TIMEOUT = 255
) (
   input  wire logic       clk,
   input  wire logic       rst,
   rinv_seq_ctrl_if.master bus
);
   localparam int         NELEM    = 9;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] LAST_IDX = 4'(NELEM - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_CALC = 3'd3,
      READ      = 3'd4,
      DRAIN     = 3'd5
   } state_t;

   state_t          state;
   logic [SIZE-1:0] rin      [0:5];
   logic [SIZE-1:0] elem_buf [0:NELEM-1];
   logic [2:0]      ld_cnt;
   logic [7:0]      tmo_cnt;
   logic [3:0]      rd_cnt;
   logic [3:0]      rd_ptr;
   logic [3:0]      rd_ptr_nxt;
   logic            seen_low;
   logic            in_ready;
   logic            in_fire;
   logic            rinv_start;
   logic            rinv_read;
   logic            out_valid;
   logic            out_last;
   logic [SIZE-1:0] out_data;
   logic            err_timeout;

   assign in_fire    = bus.in_valid && in_ready;
   assign rd_ptr_nxt = rd_ptr + 4'd1;

`ifdef RINV_SEQ_SINGULAR_CHECK_EN
   logic err_singular;
   logic singular;
   // rin_22 arrives with the final word, so it is checked on the bus directly
   assign singular = (rin[0] == '0) || (rin[3] == '0) || (bus.in_data == '0);
   assign bus.err_singular = err_singular;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ld_cnt      <= '0;
         tmo_cnt     <= '0;
         rd_cnt      <= '0;
         rd_ptr      <= '0;
         seen_low    <= 1'b0;
         in_ready    <= 1'b0;
         rinv_start  <= 1'b0;
         rinv_read   <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         err_timeout <= 1'b0;
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
         err_singular <= 1'b0;
`endif
         for (int i = 0; i < 6; i++)     rin[i]      <= '0;
         for (int i = 0; i < NELEM; i++) elem_buf[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_fire) begin
                  rin[0]      <= bus.in_data;
                  ld_cnt      <= 3'd1;
                  err_timeout <= 1'b0;
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
                  err_singular <= 1'b0;
`endif
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (in_fire) begin
                  rin[ld_cnt] <= bus.in_data;
                  ld_cnt      <= ld_cnt + 3'd1;
                  if (ld_cnt == 3'd5) begin
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
                     if (singular) begin
                        err_singular <= 1'b1;
                        state        <= IDLE;
                     end else begin
                        in_ready   <= 1'b0;
                        rinv_start <= 1'b1;
                        state      <= START;
                     end
`else
                     in_ready   <= 1'b0;
                     rinv_start <= 1'b1;
                     state      <= START;
`endif
                  end
               end
            end
            START: begin
               rinv_start <= 1'b0;
               seen_low   <= 1'b0;
               tmo_cnt    <= '0;
               state      <= WAIT_CALC;
            end
            WAIT_CALC: begin
               // dnload may still be high from the last run; only a fresh rise counts
               if (!bus.rinv_dnload) seen_low <= 1'b1;
               if (seen_low && bus.rinv_dnload) begin
                  rinv_read <= 1'b1;
                  rd_cnt    <= '0;
                  state     <= READ;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  in_ready    <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            READ: begin
               // element for read cycle k arrives one cycle later
               if (rd_cnt != 4'd0) elem_buf[rd_cnt - 4'd1] <= bus.rinv_elem;
               rinv_read <= (rd_cnt < LAST_IDX);
               rd_cnt    <= rd_cnt + 4'd1;
               if (rd_cnt == LAST_IDX + 4'd1) begin
                  if (bus.rinv_finish) begin
                     out_valid <= 1'b1;
                     out_data  <= elem_buf[0];
                     out_last  <= 1'b0;
                     rd_ptr    <= '0;
                     state     <= DRAIN;
                  end else begin
                     err_timeout <= 1'b1;
                     in_ready    <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (rd_ptr == LAST_IDX) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     rd_ptr    <= '0;
                     in_ready  <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     rd_ptr   <= rd_ptr_nxt;
                     out_data <= elem_buf[rd_ptr_nxt];
                     out_last <= (rd_ptr_nxt == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.rin_00      = rin[0];
   assign bus.rin_01      = rin[1];
   assign bus.rin_02      = rin[2];
   assign bus.rin_11      = rin[3];
   assign bus.rin_12      = rin[4];
   assign bus.rin_22      = rin[5];
   assign bus.rinv_start  = rinv_start;
   assign bus.rinv_read   = rinv_read;
   assign bus.out_valid   = out_valid;
   assign bus.out_data    = out_data;
   assign bus.out_last    = out_last;
   assign bus.busy        = (state != IDLE);
   assign bus.err_timeout = err_timeout;
endmodule
`default_nettype wire

// File: tb/tb_rinv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rinv_seq_ctrl
// Brief    : Directed self-checking bench for rinv_seq_ctrl with a datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rinv_seq_ctrl;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rinv_seq_ctrl_if #(.SIZE(16)) bus ();
   rinv_seq_ctrl #(.SIZE(16), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Datapath model: dnload falls lo_at cycles after start, rises at hi_at (0 = never)
   int          lo_at = 1;
   int          hi_at = 20;
   int          cyc = 1000;
   int          start_cnt = 0;
   int          read_cnt = 0;
   int          first_read = -1;
   int          eidx = 0;
   logic        rd_prev = 1'b0;
   logic [15:0] mdata [0:8];

   always @(negedge clk) begin
      if (rst) begin
         bus.rinv_dnload = 1'b0;
         bus.rinv_finish = 1'b0;
         bus.rinv_elem   = '0;
         rd_prev         = 1'b0;
      end else begin
         cyc++;
         if (bus.rinv_start) begin start_cnt++; cyc = 0; eidx = 0; end
         if (cyc == lo_at) bus.rinv_dnload = 1'b0;
         if (hi_at > 0 && cyc == hi_at) bus.rinv_dnload = 1'b1;
         if (rd_prev && eidx < 9) begin
            bus.rinv_elem   = mdata[eidx];
            bus.rinv_finish = (eidx == 8);
            eidx++;
         end else begin
            bus.rinv_elem   = '0;
            bus.rinv_finish = 1'b0;
         end
         if (bus.rinv_read && !rd_prev) first_read = cyc;
         if (bus.rinv_read) read_cnt++;
         rd_prev = bus.rinv_read;
      end
   end

   logic [15:0] got      [0:8];
   logic        got_last [0:8];
   int          n_got;
   int          stall_bad;
   int          lat;
   bit          load_ok;

   task automatic send_word(input logic [15:0] d, output bit ok);
      int g = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
      ok = bus.in_ready;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic load6(input logic [5:0][15:0] w);
      bit ok;
      load_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_word(w[i], ok);
         if (!ok) load_ok = 1'b0;
      end
   endtask

   task automatic wait_valid();
      lat = 0;
      while (!bus.out_valid && lat < 400) begin @(negedge clk); lat++; end
      if (!bus.out_valid) lat = -1;
   endtask

   task automatic drain(input logic [3:0] pat);
      int          g = 0;
      logic [15:0] held = '0;
      bit          stalled = 1'b0;
      n_got = 0;
      stall_bad = 0;
      while (n_got < 9 && g < 100) begin
         if (!bus.out_valid) stall_bad++;
         else if (stalled && bus.out_data !== held) stall_bad++;
         bus.out_ready = pat[g[1:0]];
         if (bus.out_ready && bus.out_valid) begin
            got[n_got] = bus.out_data;
            got_last[n_got] = bus.out_last;
            n_got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = bus.out_data;
         end
         g++;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.rinv_start, bus.rinv_read, bus.err_timeout} !== 7'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.rinv_start, bus.rinv_read, bus.err_timeout});
      end
      n_cmp++;
      if ({bus.rin_00, bus.rin_22, bus.out_data} !== 48'h0) begin
         n_bad++; $display("FAIL reset_data: got %h expected 0", {bus.rin_00, bus.rin_22, bus.out_data});
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_identity();
      logic [5:0][15:0] w;
      int s0, r0;
      w[0] = 16'h1000; w[1] = 16'h0100; w[2] = 16'h0010;
      w[3] = 16'h1000; w[4] = 16'h0100; w[5] = 16'h1000;
      mdata[0] = 16'h1000; mdata[1] = 16'hFF00; mdata[2] = 16'h0010;
      mdata[3] = 16'h8001; mdata[4] = 16'h1000; mdata[5] = 16'hFF00;
      mdata[6] = 16'h7FFF; mdata[7] = 16'h0001; mdata[8] = 16'h1000;
      lo_at = 1; hi_at = 20;
      s0 = start_cnt; r0 = read_cnt;
      load6(w);
      n_cmp++;
      if (!load_ok) begin n_bad++; $display("FAIL id_load: got ok=%0d expected 1", load_ok); end
      n_cmp++;
      if (bus.rinv_start !== 1'b1) begin n_bad++; $display("FAIL id_start: got %b expected 1", bus.rinv_start); end
      n_cmp++;
      if ({bus.rin_22, bus.rin_12, bus.rin_11, bus.rin_02, bus.rin_01, bus.rin_00} !== w) begin
         n_bad++; $display("FAIL id_rin: got %h expected %h", {bus.rin_22, bus.rin_12, bus.rin_11, bus.rin_02, bus.rin_01, bus.rin_00}, w);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.rinv_start !== 1'b0) begin n_bad++; $display("FAIL id_start_pulse: got %b expected 0", bus.rinv_start); end
      wait_valid();
      n_cmp++;
      if (lat != 30) begin n_bad++; $display("FAIL id_latency: got %0d expected 30", lat); end
      n_cmp++;
      if (first_read != 21) begin n_bad++; $display("FAIL id_first_read: got %0d expected 21", first_read); end
      drain(4'b1111);
      n_cmp++;
      if (n_got != 9) begin n_bad++; $display("FAIL id_count: got %0d expected 9", n_got); end
      for (int i = 0; i < n_got; i++) begin
         n_cmp++;
         if (got[i] !== mdata[i] || got_last[i] !== (i == 8)) begin
            n_bad++; $display("FAIL id_elem%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], mdata[i], (i == 8));
         end
      end
      n_cmp++;
      if (start_cnt - s0 != 1 || read_cnt - r0 != 9) begin
         n_bad++; $display("FAIL id_pulses: got start %0d read %0d expected 1 9", start_cnt - s0, read_cnt - r0);
      end
      n_cmp++;
      if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin
         n_bad++; $display("FAIL id_end: got %b expected 001", {bus.busy, bus.out_valid, bus.in_ready});
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0][15:0] w;
      w[0] = 16'h2000; w[1] = 16'hF123; w[2] = 16'h0456;
      w[3] = 16'h1800; w[4] = 16'h0ABC; w[5] = 16'h0C00;
      for (int i = 0; i < 9; i++) mdata[i] = 16'hA000 + 16'(i * 16'h0111);
      lo_at = 6; hi_at = 14;
      load6(w);
      wait_valid();
      n_cmp++;
      if (first_read != 15) begin n_bad++; $display("FAIL b2b_first_read: got %0d expected 15", first_read); end
      n_cmp++;
      if (lat != 25) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 25", lat); end
      drain(4'b1111);
      n_cmp++;
      if (n_got != 9) begin n_bad++; $display("FAIL b2b_count: got %0d expected 9", n_got); end
      for (int i = 0; i < n_got; i++) begin
         n_cmp++;
         if (got[i] !== mdata[i]) begin n_bad++; $display("FAIL b2b_elem%0d: got %h expected %h", i, got[i], mdata[i]); end
      end
   endtask

   task automatic test_timeout();
      logic [5:0][15:0] w;
      bit ok;
      int r0;
      w[0] = 16'h1000; w[1] = 16'h0200; w[2] = 16'h0030;
      w[3] = 16'h1000; w[4] = 16'h0400; w[5] = 16'h1000;
      lo_at = 1; hi_at = 0;
      r0 = read_cnt;
      load6(w);
      repeat (TIMEOUT) @(negedge clk);
      n_cmp++;
      if ({bus.err_timeout, bus.busy} !== 2'b01) begin
         n_bad++; $display("FAIL tmo_early: got err/busy %b expected 01", {bus.err_timeout, bus.busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.err_timeout, bus.busy} !== 2'b10) begin
         n_bad++; $display("FAIL tmo_fire: got err/busy %b expected 10", {bus.err_timeout, bus.busy});
      end
      n_cmp++;
      if (read_cnt != r0) begin n_bad++; $display("FAIL tmo_no_read: got %0d expected 0", read_cnt - r0); end
      hi_at = 10;
      for (int i = 0; i < 9; i++) mdata[i] = 16'h0F00 - 16'(i);
      send_word(w[0], ok);
      n_cmp++;
      if (bus.err_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got %b expected 0", bus.err_timeout); end
      for (int i = 1; i < 6; i++) send_word(w[i], ok);
      wait_valid();
      n_cmp++;
      if (lat != 21) begin n_bad++; $display("FAIL tmo_recover_latency: got %0d expected 21", lat); end
      drain(4'b1111);
      for (int i = 0; i < n_got; i++) begin
         n_cmp++;
         if (got[i] !== mdata[i]) begin n_bad++; $display("FAIL tmo_elem%0d: got %h expected %h", i, got[i], mdata[i]); end
      end
   endtask

   task automatic test_stall();
      logic [5:0][15:0] w;
      w[0] = 16'h0800; w[1] = 16'h0001; w[2] = 16'hFFFF;
      w[3] = 16'h0800; w[4] = 16'h0002; w[5] = 16'h0800;
      for (int i = 0; i < 9; i++) mdata[i] = 16'h5A00 ^ 16'(i * 16'h1013);
      lo_at = 1; hi_at = 8;
      load6(w);
      wait_valid();
      n_cmp++;
      if (lat != 19) begin n_bad++; $display("FAIL stall_latency: got %0d expected 19", lat); end
      drain(4'b1001);
      n_cmp++;
      if (n_got != 9 || stall_bad != 0) begin
         n_bad++; $display("FAIL stall_flow: got count %0d unstable %0d expected 9 0", n_got, stall_bad);
      end
      for (int i = 0; i < n_got; i++) begin
         n_cmp++;
         if (got[i] !== mdata[i] || got_last[i] !== (i == 8)) begin
            n_bad++; $display("FAIL stall_elem%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], mdata[i], (i == 8));
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [5:0][15:0] w;
      w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
      w[3] = 16'h4444; w[4] = 16'h5555; w[5] = 16'h6666;
      for (int i = 0; i < 9; i++) mdata[i] = 16'hC000 + 16'(i);
      lo_at = 1; hi_at = 10;
      load6(w);
      repeat (15) @(negedge clk);
      n_cmp++;
      if (bus.rinv_read !== 1'b1) begin n_bad++; $display("FAIL rst_in_read: got %b expected 1", bus.rinv_read); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.rinv_start, bus.rinv_read, bus.err_timeout} !== 6'b0 ||
          {bus.rin_00, bus.rin_12, bus.out_data} !== 48'h0) begin
         n_bad++; $display("FAIL rst_async: got %b %h expected all zero",
            {bus.in_ready, bus.busy, bus.out_valid, bus.rinv_start, bus.rinv_read, bus.err_timeout}, {bus.rin_00, bus.rin_12, bus.out_data});
      end
      @(negedge clk);
      rst = 1'b0;
      load6(w);
      wait_valid();
      n_cmp++;
      if (lat != 21) begin n_bad++; $display("FAIL rst_reload_latency: got %0d expected 21", lat); end
      drain(4'b1111);
      n_cmp++;
      if (n_got != 9) begin n_bad++; $display("FAIL rst_reload_count: got %0d expected 9", n_got); end
      for (int i = 0; i < n_got; i++) begin
         n_cmp++;
         if (got[i] !== mdata[i]) begin n_bad++; $display("FAIL rst_elem%0d: got %h expected %h", i, got[i], mdata[i]); end
      end
   endtask

`ifdef RINV_SEQ_SINGULAR_CHECK_EN
   task automatic test_singular();
      logic [5:0][15:0] w;
      bit ok;
      int s0;
      w[0] = 16'h1000; w[1] = 16'h0100; w[2] = 16'h0010;
      w[3] = 16'h0000; w[4] = 16'h0100; w[5] = 16'h1000;
      s0 = start_cnt;
      load6(w);
      n_cmp++;
      if ({bus.rinv_start, bus.err_singular, bus.busy} !== 3'b010) begin
         n_bad++; $display("FAIL sing_flag: got start/err/busy %b expected 010", {bus.rinv_start, bus.err_singular, bus.busy});
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (start_cnt != s0) begin n_bad++; $display("FAIL sing_no_start: got %0d expected 0", start_cnt - s0); end
      send_word(16'h1000, ok);
      n_cmp++;
      if (bus.err_singular !== 1'b0) begin n_bad++; $display("FAIL sing_clear: got %b expected 0", bus.err_singular); end
   endtask
`endif

   initial begin
      test_reset();
      test_identity();
      test_back_to_back();
      test_timeout();
      test_stall();
      test_reset_mid_read();
`ifdef RINV_SEQ_SINGULAR_CHECK_EN
      test_singular();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
